mac_sequencer: RTL and testbench

- Time-multiplexed dot-product engine. Computes the sum of coef[k]*samp[k] for k = 0 .. len-1.
- Uses one combinational Q(P).(F) saturating multiplier (the team's Mult block) and a saturating accumulator.
- Fetches operand pairs from external synchronous-read coefficient and sample memories.
- Sits between the filter control logic and the shared multiplier. It is the only block that drives the multiplier's A/B inputs.

---
 rtl/mac_sequencer_pkg.sv | 16 +
 rtl/mult.sv | 31 +++
 rtl/sat_add.sv | 27 ++
 rtl/mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_mac_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared fixed-point constants and sequencer state encodings.
package mac_sequencer_pkg;

   localparam int F     = 10;
   localparam int P     = 5;
   localparam int WIDTH = F + P + 1;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mult.sv
// Combinational Q(P).(F) signed saturating multiplier, truncating the fraction.
module mult #(
   parameter int F = 10,
   parameter int P = 5
) (
   input  logic [F+P:0] a,
   input  logic [F+P:0] b,
   output logic [F+P:0] p
);

   localparam int WIDTH = F + P + 1;
   localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] full;
   logic signed [2*WIDTH-1:0] shifted;
   logic        [WIDTH:0]     hi;

   // Product fits only if all bits above the result's sign bit match it.
   always_comb begin
      full    = $signed(a) * $signed(b);
      shifted = full >>> F;
      hi      = shifted[2*WIDTH-1:WIDTH-1];
      if ((&hi) || !(|hi)) begin
         p = shifted[WIDTH-1:0];
      end else begin
         p = shifted[2*WIDTH-1] ? MinVal : MaxVal;
      end
   end

endmodule

// File: rtl/sat_add.sv
// Combinational WIDTH-bit signed saturating adder with overflow flag.
module sat_add #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] s;

   // One extra sign bit exposes overflow; clamp toward the sign of the true sum.
   always_comb begin
      s   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      ovf = s[WIDTH] ^ s[WIDTH-1];
      if (ovf) begin
         sum = s[WIDTH] ? MinVal : MaxVal;
      end else begin
         sum = s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Time-multiplexed dot-product engine: reads len operand pairs from external
// synchronous memories and accumulates their products with saturation.
module mac_sequencer #(
   parameter int F      = mac_sequencer_pkg::F,
   parameter int P      = mac_sequencer_pkg::P,
   parameter int WIDTH  = F + P + 1,
   parameter int N_TAPS = 8,
   parameter int AW     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [AW:0]      n_taps,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] coef_in,
   input  logic [WIDTH-1:0] samp_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             sat
);

   import mac_sequencer_pkg::*;

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW:0]      len_q, len_d;
   logic [AW:0]      len_clamp;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             sat_q, sat_d;
   logic             vld_q;
   logic [WIDTH-1:0] mult_a, mult_b, prod, acc_sum;
   logic             acc_ovf;

   // Multiplier sees zeros unless memory data is valid this cycle.
   always_comb begin
      mult_a = vld_q ? coef_in : '0;
      mult_b = vld_q ? samp_in : '0;
   end

   mult #(
      .F (F),
      .P (P)
   ) u_mult (
      .a (mult_a),
      .b (mult_b),
      .p (prod)
   );

   sat_add #(
      .WIDTH (WIDTH)
   ) u_sat_add (
      .a   (acc_q),
      .b   (prod),
      .sum (acc_sum),
      .ovf (acc_ovf)
   );

   // Next-state logic for FSM, tap index, accumulator, result and sticky flag.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      result_d  = result_q;
      len_clamp = (n_taps > (AW+1)'(N_TAPS)) ? (AW+1)'(N_TAPS) : n_taps;

      if (vld_q) begin
         acc_d = acc_sum;
         if (acc_ovf) sat_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d = len_clamp;
               acc_d = '0;
               sat_d = 1'b0;
               idx_d = '0;
               if (len_clamp == '0) begin
                  result_d = '0;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if ({1'b0, idx_q} == len_q - (AW+1)'(1)) begin
               idx_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         ST_DRAIN: begin
            // Final product lands on this edge; capture it so result is valid with done.
            result_d = acc_sum;
            state_d  = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         sat_q    <= sat_d;
         vld_q    <= rd_en;
      end
   end

   // Outputs decoded from state and registers.
   always_comb begin
      rd_en   = (state_q == ST_RUN);
      rd_addr = idx_q;
      busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      done    = (state_q == ST_DONE);
      result  = result_q;
      sat     = sat_q;
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed cases plus randomized runs
// compared against an arithmetic dot-product model.
module tb_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  n_taps;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [15:0] coef_in;
   logic [15:0] samp_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        sat;

   logic [15:0] coef_mem [8];
   logic [15:0] samp_mem [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_sequencer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .n_taps  (n_taps),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .coef_in (coef_in),
      .samp_in (samp_in),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .sat     (sat)
   );

   // Synchronous-read memories; garbage on the bus when not reading.
   always @(posedge clk) begin
      if (rd_en) begin
         coef_in <= coef_mem[rd_addr];
         samp_in <= samp_mem[rd_addr];
      end else begin
         coef_in <= 16'($urandom);
         samp_in <= 16'($urandom);
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Dot product in plain integer arithmetic with per-step accumulator clipping.
   function automatic logic [15:0] model(input int len, output bit s);
      longint acc = 0;
      longint p;
      s = 1'b0;
      for (int k = 0; k < len; k++) begin
         p = longint'($signed(coef_mem[k])) * longint'($signed(samp_mem[k]));
         p = p >>> 10;
         if (p > 32767) p = 32767;
         if (p < -32768) p = -32768;
         acc = acc + p;
         if (acc > 32767) begin
            acc = 32767;
            s = 1'b1;
         end else if (acc < -32768) begin
            acc = -32768;
            s = 1'b1;
         end
      end
      return 16'(acc);
   endfunction

   task automatic run_case(input string name, input int n, input bit hazard);
      int len;
      int reads;
      int done_cyc;
      int seq_err;
      int extra;
      bit exp_sat;
      logic [15:0] exp_res;
      logic [15:0] got_res;
      logic got_sat;
      len      = (n > 8) ? 8 : n;
      exp_res  = model(len, exp_sat);
      reads    = 0;
      done_cyc = 0;
      seq_err  = 0;
      extra    = 0;
      got_res  = '0;
      got_sat  = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      n_taps = 4'(n);
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         @(negedge clk);
         if (rd_en) begin
            if (int'(rd_addr) != reads) seq_err++;
            reads++;
         end
         if (rd_en !== (c >= 1 && c <= len)) seq_err++;
         if (busy !== (len > 0 && c <= len + 1)) seq_err++;
         if (done) begin
            done_cyc = c;
            got_res  = result;
            got_sat  = sat;
         end
         if (hazard && len >= 1 && c == 2) start = 1'b1;
         else start = 1'b0;
      end
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done) extra++;
         if (result !== got_res) seq_err++;
      end
      check({name, ".done_cycle"}, done_cyc, (len == 0) ? 1 : len + 2);
      check({name, ".reads"}, reads, len);
      check({name, ".sequence"}, seq_err, 0);
      check({name, ".result"}, got_res, exp_res);
      check({name, ".sat"}, got_sat, exp_sat);
      check({name, ".extra_done"}, extra, 0);
   endtask

   task automatic fill(input logic [15:0] c, input logic [15:0] s);
      for (int k = 0; k < 8; k++) begin
         coef_mem[k] = c;
         samp_mem[k] = s;
      end
   endtask

   initial begin
      int dones;
      rst_n  = 1'b0;
      start  = 1'b0;
      n_taps = '0;
      fill(16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.result", result, 0);
      check("reset.sat", sat, 0);
      check("reset.rd_en", rd_en, 0);
      check("reset.rd_addr", rd_addr, 0);
      rst_n = 1'b1;

      fill(16'h0400, 16'h0200);
      run_case("nominal", 4, 1'b0);
      check("nominal.value", result, 16'h0800);
      fill(16'h1000, 16'h1000);
      run_case("pos_sat", 8, 1'b0);
      check("pos_sat.value", result, 16'h7FFF);
      fill(16'hFC00, 16'h1000);
      run_case("neg_limit", 8, 1'b0);
      check("neg_limit.value", result, 16'h8000);
      fill(16'h0400, 16'h4000);
      samp_mem[2] = 16'hC000;
      run_case("recover", 3, 1'b0);
      check("recover.value", result, 16'h3FFF);
      run_case("zero_len", 0, 1'b0);
      fill(16'h0400, 16'h0100);
      run_case("clamp", 12, 1'b0);
      run_case("restart", 5, 1'b1);

      // Reset asserted in cycle 3 of an 8-tap run aborts it.
      fill(16'h0400, 16'h0200);
      @(negedge clk);
      start  = 1'b1;
      n_taps = 4'd8;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.result", result, 0);
      check("abort.rd_en", rd_en, 0);
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort.no_done", dones, 0);

      for (int r = 0; r < 24; r++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int k = 0; k < 8; k++) begin
            if (mode == 0) begin
               coef_mem[k] = 16'($urandom);
               samp_mem[k] = 16'($urandom);
            end else begin
               coef_mem[k] = 16'($urandom_range(0, 4095) - 2048);
               samp_mem[k] = 16'($urandom_range(0, 4095) - 2048);
            end
         end
         run_case($sformatf("rand%0d", r), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
